alu_rs: RTL and testbench

Reservation station that feeds the integer ALU. It sits between the dispatcher and the ALU.
- Buffers up to DEPTH decoded ALU instructions.
- Snoops two result broadcast buses (CDBs) to resolve pending operands.
- Issues at most one ready instruction per cycle on registered outputs.
- Discards all contents on a branch mispredict, and clears freed branch-tag bits in stored entries.

---
 rtl/alu_rs_pkg.sv | 25 ++
 rtl/alu_rs_pick.sv | 12 +
 rtl/alu_rs.sv | 252 +++++++++++++++++++++++++
 tb/tb_alu_rs.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared widths, free-value constants and ALU opcodes for the ALU reservation station.
package alu_rs_pkg;
    localparam int TagBus       = 4;
    localparam int DataBus      = 32;
    localparam int OpBus        = 5;
    localparam int InstAddrBus  = 32;
    localparam int BranchTagBus = 4;

    localparam logic [TagBus-1:0]      tagFree  = '0;
    localparam logic [DataBus-1:0]     dataFree = '0;
    localparam logic [InstAddrBus-1:0] addrFree = '0;
    localparam logic                   Enable   = 1'b1;
    localparam logic                   Disable  = 1'b0;

    localparam logic [OpBus-1:0] ALU_ADD  = 5'd0;
    localparam logic [OpBus-1:0] ALU_SUB  = 5'd1;
    localparam logic [OpBus-1:0] ALU_AND  = 5'd2;
    localparam logic [OpBus-1:0] ALU_OR   = 5'd3;
    localparam logic [OpBus-1:0] ALU_XOR  = 5'd4;
    localparam logic [OpBus-1:0] ALU_SLL  = 5'd5;
    localparam logic [OpBus-1:0] ALU_SRL  = 5'd6;
    localparam logic [OpBus-1:0] ALU_SRA  = 5'd7;
    localparam logic [OpBus-1:0] ALU_SLT  = 5'd8;
    localparam logic [OpBus-1:0] ALU_SLTU = 5'd9;
endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index one-hot priority picker with an any-request flag.
module rs_pick #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         any
);
    // Two's-complement trick isolates the lowest set bit.
    assign gnt = req & (~req + N'(1));
    assign any = |req;
endmodule

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: buffers dispatched instructions,
// snoops two CDBs for operands and issues the lowest-index ready entry per cycle.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = DataBus,
    parameter int TAG_W  = TagBus,
    parameter int OP_W   = OpBus,
    parameter int ADDR_W = InstAddrBus,
    parameter int BT_W   = BranchTagBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disEn,
    input  logic [OP_W-1:0]   disOpCode,
    input  logic [TAG_W-1:0]  disWrtTag,
    input  logic [DATA_W-1:0] disDataO,
    input  logic [DATA_W-1:0] disDataT,
    input  logic [TAG_W-1:0]  disTagO,
    input  logic [TAG_W-1:0]  disTagT,
    input  logic [ADDR_W-1:0] disInstAddr,
    input  logic [BT_W-1:0]   disBranchTag,
    output logic              rsFull,
    input  logic              cdbAEn,
    input  logic [TAG_W-1:0]  cdbATag,
    input  logic [DATA_W-1:0] cdbAData,
    input  logic              cdbBEn,
    input  logic [TAG_W-1:0]  cdbBTag,
    input  logic [DATA_W-1:0] cdbBData,
    input  logic              misTaken,
    input  logic              bFreeEn,
    input  logic [1:0]        bFreeNum,
    output logic              ALUworkEn,
    output logic [DATA_W-1:0] operandO,
    output logic [DATA_W-1:0] operandT,
    output logic [TAG_W-1:0]  wrtTag,
    output logic [OP_W-1:0]   opCode,
    output logic [ADDR_W-1:0] instAddr,
    output logic [BT_W-1:0]   instBranchTag
);
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [OP_W-1:0]   op_q     [DEPTH];
    logic [OP_W-1:0]   op_d     [DEPTH];
    logic [TAG_W-1:0]  wtag_q   [DEPTH];
    logic [TAG_W-1:0]  wtag_d   [DEPTH];
    logic [DATA_W-1:0] data_o_q [DEPTH];
    logic [DATA_W-1:0] data_o_d [DEPTH];
    logic [DATA_W-1:0] data_t_q [DEPTH];
    logic [DATA_W-1:0] data_t_d [DEPTH];
    logic [TAG_W-1:0]  tag_o_q  [DEPTH];
    logic [TAG_W-1:0]  tag_o_d  [DEPTH];
    logic [TAG_W-1:0]  tag_t_q  [DEPTH];
    logic [TAG_W-1:0]  tag_t_d  [DEPTH];
    logic [ADDR_W-1:0] addr_q   [DEPTH];
    logic [ADDR_W-1:0] addr_d   [DEPTH];
    logic [BT_W-1:0]   bt_q     [DEPTH];
    logic [BT_W-1:0]   bt_d     [DEPTH];

    logic              work_en_q, work_en_d;
    logic [DATA_W-1:0] opnd_o_q, opnd_o_d, opnd_t_q, opnd_t_d;
    logic [TAG_W-1:0]  out_wtag_q, out_wtag_d;
    logic [OP_W-1:0]   out_op_q, out_op_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [BT_W-1:0]   out_bt_q, out_bt_d;

    logic [DEPTH-1:0]  ready, free_gnt, rdy_gnt;
    logic              free_any, rdy_any, dis_go;
    logic [BT_W-1:0]   bt_keep;
    logic [DATA_W-1:0] fwd_data_o, fwd_data_t;
    logic [TAG_W-1:0]  fwd_tag_o, fwd_tag_t;
    logic [DATA_W-1:0] iss_data_o, iss_data_t;
    logic [TAG_W-1:0]  iss_wtag;
    logic [OP_W-1:0]   iss_op;
    logic [ADDR_W-1:0] iss_addr;
    logic [BT_W-1:0]   iss_bt;

    function automatic logic hit(input logic en, input logic [TAG_W-1:0] bus_tag,
                                 input logic [TAG_W-1:0] tag);
        return en && (tag != TAG_W'(tagFree)) && (bus_tag == tag);
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = valid_q[i] && (tag_o_q[i] == '0) && (tag_t_q[i] == '0);
        end
    end

    rs_pick #(.N(DEPTH)) u_free_pick  (.req(~valid_q), .gnt(free_gnt), .any(free_any));
    rs_pick #(.N(DEPTH)) u_ready_pick (.req(ready),    .gnt(rdy_gnt),  .any(rdy_any));

    assign rsFull  = ~free_any;
    assign dis_go  = disEn && !rsFull && !misTaken;
    assign bt_keep = bFreeEn ? ~(BT_W'(1) << bFreeNum) : '1;

    // Same-cycle forwarding for the incoming instruction; CDB A wins a tie.
    always_comb begin
        fwd_data_o = disDataO;
        fwd_tag_o  = disTagO;
        fwd_data_t = disDataT;
        fwd_tag_t  = disTagT;
        if (hit(cdbAEn, cdbATag, disTagO)) begin
            fwd_data_o = cdbAData;
            fwd_tag_o  = '0;
        end else if (hit(cdbBEn, cdbBTag, disTagO)) begin
            fwd_data_o = cdbBData;
            fwd_tag_o  = '0;
        end
        if (hit(cdbAEn, cdbATag, disTagT)) begin
            fwd_data_t = cdbAData;
            fwd_tag_t  = '0;
        end else if (hit(cdbBEn, cdbBTag, disTagT)) begin
            fwd_data_t = cdbBData;
            fwd_tag_t  = '0;
        end
    end

    always_comb begin
        iss_data_o = '0;
        iss_data_t = '0;
        iss_wtag   = '0;
        iss_op     = '0;
        iss_addr   = '0;
        iss_bt     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy_gnt[i]) begin
                iss_data_o = iss_data_o | data_o_q[i];
                iss_data_t = iss_data_t | data_t_q[i];
                iss_wtag   = iss_wtag   | wtag_q[i];
                iss_op     = iss_op     | op_q[i];
                iss_addr   = iss_addr   | addr_q[i];
                iss_bt     = iss_bt     | bt_q[i];
            end
        end
    end

    always_comb begin
        valid_d    = valid_q;
        op_d       = op_q;
        wtag_d     = wtag_q;
        data_o_d   = data_o_q;
        data_t_d   = data_t_q;
        tag_o_d    = tag_o_q;
        tag_t_d    = tag_t_q;
        addr_d     = addr_q;
        bt_d       = bt_q;
        work_en_d  = Disable;
        opnd_o_d   = DATA_W'(dataFree);
        opnd_t_d   = DATA_W'(dataFree);
        out_wtag_d = TAG_W'(tagFree);
        out_op_d   = '0;
        out_addr_d = ADDR_W'(addrFree);
        out_bt_d   = '0;
        if (misTaken) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                bt_d[i] = bt_q[i] & bt_keep;
                if (hit(cdbAEn, cdbATag, tag_o_q[i])) begin
                    data_o_d[i] = cdbAData;
                    tag_o_d[i]  = '0;
                end else if (hit(cdbBEn, cdbBTag, tag_o_q[i])) begin
                    data_o_d[i] = cdbBData;
                    tag_o_d[i]  = '0;
                end
                if (hit(cdbAEn, cdbATag, tag_t_q[i])) begin
                    data_t_d[i] = cdbAData;
                    tag_t_d[i]  = '0;
                end else if (hit(cdbBEn, cdbBTag, tag_t_q[i])) begin
                    data_t_d[i] = cdbBData;
                    tag_t_d[i]  = '0;
                end
            end
            if (rdy_any) begin
                valid_d    = valid_d & ~rdy_gnt;
                work_en_d  = Enable;
                opnd_o_d   = iss_data_o;
                opnd_t_d   = iss_data_t;
                out_wtag_d = iss_wtag;
                out_op_d   = iss_op;
                out_addr_d = iss_addr;
                out_bt_d   = iss_bt & bt_keep;
            end
            // Free slot comes from pre-edge valid bits, so it never aliases the issued slot.
            if (dis_go) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (free_gnt[i]) begin
                        valid_d[i]  = 1'b1;
                        op_d[i]     = disOpCode;
                        wtag_d[i]   = disWrtTag;
                        data_o_d[i] = fwd_data_o;
                        data_t_d[i] = fwd_data_t;
                        tag_o_d[i]  = fwd_tag_o;
                        tag_t_d[i]  = fwd_tag_t;
                        addr_d[i]   = disInstAddr;
                        bt_d[i]     = disBranchTag & bt_keep;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            work_en_q  <= Disable;
            opnd_o_q   <= '0;
            opnd_t_q   <= '0;
            out_wtag_q <= '0;
            out_op_q   <= '0;
            out_addr_q <= '0;
            out_bt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]     <= '0;
                wtag_q[i]   <= '0;
                data_o_q[i] <= '0;
                data_t_q[i] <= '0;
                tag_o_q[i]  <= '0;
                tag_t_q[i]  <= '0;
                addr_q[i]   <= '0;
                bt_q[i]     <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            work_en_q  <= work_en_d;
            opnd_o_q   <= opnd_o_d;
            opnd_t_q   <= opnd_t_d;
            out_wtag_q <= out_wtag_d;
            out_op_q   <= out_op_d;
            out_addr_q <= out_addr_d;
            out_bt_q   <= out_bt_d;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]     <= op_d[i];
                wtag_q[i]   <= wtag_d[i];
                data_o_q[i] <= data_o_d[i];
                data_t_q[i] <= data_t_d[i];
                tag_o_q[i]  <= tag_o_d[i];
                tag_t_q[i]  <= tag_t_d[i];
                addr_q[i]   <= addr_d[i];
                bt_q[i]     <= bt_d[i];
            end
        end
    end

    assign ALUworkEn     = work_en_q;
    assign operandO      = opnd_o_q;
    assign operandT      = opnd_t_q;
    assign wrtTag        = out_wtag_q;
    assign opCode        = out_op_q;
    assign instAddr      = out_addr_q;
    assign instBranchTag = out_bt_q;
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: behavioural slot model checked every cycle plus literal spot checks.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic        clk = 0;
    logic        rst = 0;
    logic        disEn;
    logic [4:0]  disOpCode;
    logic [3:0]  disWrtTag, disTagO, disTagT, disBranchTag;
    logic [31:0] disDataO, disDataT, disInstAddr;
    logic        rsFull;
    logic        cdbAEn, cdbBEn;
    logic [3:0]  cdbATag, cdbBTag;
    logic [31:0] cdbAData, cdbBData;
    logic        misTaken, bFreeEn;
    logic [1:0]  bFreeNum;
    logic        ALUworkEn;
    logic [31:0] operandO, operandT, instAddr;
    logic [3:0]  wrtTag, instBranchTag;
    logic [4:0]  opCode;

    int vectors = 0;
    int miscompares = 0;

    alu_rs dut (
        .clk(clk), .rst(rst),
        .disEn(disEn), .disOpCode(disOpCode), .disWrtTag(disWrtTag),
        .disDataO(disDataO), .disDataT(disDataT), .disTagO(disTagO), .disTagT(disTagT),
        .disInstAddr(disInstAddr), .disBranchTag(disBranchTag), .rsFull(rsFull),
        .cdbAEn(cdbAEn), .cdbATag(cdbATag), .cdbAData(cdbAData),
        .cdbBEn(cdbBEn), .cdbBTag(cdbBTag), .cdbBData(cdbBData),
        .misTaken(misTaken), .bFreeEn(bFreeEn), .bFreeNum(bFreeNum),
        .ALUworkEn(ALUworkEn), .operandO(operandO), .operandT(operandT),
        .wrtTag(wrtTag), .opCode(opCode), .instAddr(instAddr),
        .instBranchTag(instBranchTag)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: eight slots, filled lowest-free-first, issued lowest-ready-first.
    logic        m_valid [8];
    logic [4:0]  m_op    [8];
    logic [3:0]  m_wt    [8], m_to [8], m_tt [8], m_bt [8];
    logic [31:0] m_do    [8], m_dt [8], m_ad [8];
    logic        e_en = 0;
    logic [31:0] e_o = 0, e_t = 0, e_ad = 0;
    logic [3:0]  e_wt = 0, e_bt = 0;
    logic [4:0]  e_op = 0;
    int          m_r, m_f;
    logic        m_full;
    logic [3:0]  m_bm;

    task automatic snoop(inout logic [3:0] tag, inout logic [31:0] data);
        if (tag != 0) begin
            if (cdbAEn && cdbATag == tag) begin
                data = cdbAData; tag = 0;
            end else if (cdbBEn && cdbBTag == tag) begin
                data = cdbBData; tag = 0;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 0;
            e_en = 0; e_o = 0; e_t = 0; e_wt = 0; e_op = 0; e_ad = 0; e_bt = 0;
        end else if (misTaken) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 0;
            e_en = 0; e_o = 0; e_t = 0; e_wt = 0; e_op = 0; e_ad = 0; e_bt = 0;
        end else begin
            m_bm   = bFreeEn ? ~(4'b0001 << bFreeNum) : 4'b1111;
            m_full = 1; m_f = -1; m_r = -1;
            for (int i = 0; i < 8; i++) begin
                if (!m_valid[i]) begin
                    m_full = 0;
                    if (m_f < 0) m_f = i;
                end
                if (m_r < 0 && m_valid[i] && m_to[i] == 0 && m_tt[i] == 0) m_r = i;
            end
            if (m_r >= 0) begin
                e_en = 1; e_o = m_do[m_r]; e_t = m_dt[m_r]; e_wt = m_wt[m_r];
                e_op = m_op[m_r]; e_ad = m_ad[m_r]; e_bt = m_bt[m_r] & m_bm;
                m_valid[m_r] = 0;
            end else begin
                e_en = 0; e_o = 0; e_t = 0; e_wt = 0; e_op = 0; e_ad = 0; e_bt = 0;
            end
            for (int i = 0; i < 8; i++) begin
                if (m_valid[i]) begin
                    snoop(m_to[i], m_do[i]);
                    snoop(m_tt[i], m_dt[i]);
                    m_bt[i] = m_bt[i] & m_bm;
                end
            end
            if (disEn && m_full) $display("note: dispatch while rsFull at %0t is dropped", $time);
            if (disEn && !m_full) begin
                m_valid[m_f] = 1; m_op[m_f] = disOpCode; m_wt[m_f] = disWrtTag;
                m_to[m_f] = disTagO; m_do[m_f] = disDataO;
                m_tt[m_f] = disTagT; m_dt[m_f] = disDataT;
                snoop(m_to[m_f], m_do[m_f]);
                snoop(m_tt[m_f], m_dt[m_f]);
                m_ad[m_f] = disInstAddr; m_bt[m_f] = disBranchTag & m_bm;
            end
        end
    end

    function automatic logic model_full();
        logic f = 1;
        for (int i = 0; i < 8; i++) if (!m_valid[i]) f = 0;
        return f;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_rsFull", {31'b0, rsFull}, {31'b0, model_full()});
            check("cyc_ALUworkEn", {31'b0, ALUworkEn}, {31'b0, e_en});
            check("cyc_operandO", operandO, e_o);
            check("cyc_operandT", operandT, e_t);
            check("cyc_wrtTag", {28'b0, wrtTag}, {28'b0, e_wt});
            check("cyc_opCode", {27'b0, opCode}, {27'b0, e_op});
            check("cyc_instAddr", instAddr, e_ad);
            check("cyc_instBranchTag", {28'b0, instBranchTag}, {28'b0, e_bt});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disEn = 0; disOpCode = 0; disWrtTag = 0; disDataO = 0; disDataT = 0;
        disTagO = 0; disTagT = 0; disInstAddr = 0; disBranchTag = 0;
        cdbAEn = 0; cdbATag = 0; cdbAData = 0; cdbBEn = 0; cdbBTag = 0; cdbBData = 0;
        misTaken = 0; bFreeEn = 0; bFreeNum = 0;
    endtask

    task automatic dis(input logic [4:0] op, input logic [3:0] wt, input logic [31:0] d_o,
                       input logic [31:0] d_t, input logic [3:0] t_o, input logic [3:0] t_t,
                       input logic [31:0] ad, input logic [3:0] bt);
        disEn = 1; disOpCode = op; disWrtTag = wt; disDataO = d_o; disDataT = d_t;
        disTagO = t_o; disTagT = t_t; disInstAddr = ad; disBranchTag = bt;
    endtask

    initial begin
        idle();
        #2 rst = 1;
        tick(); tick();
        check("reset_ALUworkEn", {31'b0, ALUworkEn}, 32'd0);
        check("reset_rsFull", {31'b0, rsFull}, 32'd0);
        check("reset_operandO", operandO, 32'd0);
        check("reset_wrtTag", {28'b0, wrtTag}, 32'd0);
        rst = 0;
        tick();

        // ready operands: issue one cycle after dispatch
        dis(ALU_ADD, 4'd3, 32'd5, 32'd7, 4'd0, 4'd0, 32'h100, 4'd0);
        tick(); idle();
        tick();
        check("add_en", {31'b0, ALUworkEn}, 32'd1);
        check("add_opO", operandO, 32'd5);
        check("add_opT", operandT, 32'd7);
        check("add_wrtTag", {28'b0, wrtTag}, 32'd3);
        check("add_pc", instAddr, 32'h100);
        tick();
        check("add_en_drop", {31'b0, ALUworkEn}, 32'd0);

        // wakeup via CDB A two cycles after dispatch
        dis(ALU_SUB, 4'd7, 32'd0, 32'd2, 4'd4, 4'd0, 32'h104, 4'd0);
        tick(); idle();
        tick();
        cdbAEn = 1; cdbATag = 4'd4; cdbAData = 32'd9;
        tick(); idle();
        check("sub_not_yet", {31'b0, ALUworkEn}, 32'd0);
        tick();
        check("sub_en", {31'b0, ALUworkEn}, 32'd1);
        check("sub_opO", operandO, 32'd9);
        check("sub_opT", operandT, 32'd2);
        check("sub_op", {27'b0, opCode}, {27'b0, ALU_SUB});

        // same-cycle forwarding from CDB B
        dis(ALU_ADD, 4'd9, 32'd1, 32'd0, 4'd0, 4'd6, 32'h108, 4'd0);
        cdbBEn = 1; cdbBTag = 4'd6; cdbBData = 32'h11;
        tick(); idle();
        tick();
        check("fwd_en", {31'b0, ALUworkEn}, 32'd1);
        check("fwd_opT", operandT, 32'h11);

        // fill all eight slots, overflow dispatch is dropped
        for (int i = 0; i < 8; i++) begin
            dis(ALU_OR, 4'(i + 8), 32'(i), 32'(i), 4'(i + 1), 4'd0, 32'h200 + 32'(4 * i), 4'd0);
            tick();
        end
        check("full_set", {31'b0, rsFull}, 32'd1);
        dis(ALU_XOR, 4'd0, 32'd0, 32'd0, 4'd9, 4'd0, 32'h300, 4'd0);
        tick(); idle();
        check("full_hold", {31'b0, rsFull}, 32'd1);
        cdbAEn = 1; cdbATag = 4'd3; cdbAData = 32'hAA;
        cdbBEn = 1; cdbBTag = 4'd6; cdbBData = 32'hBB;
        tick(); idle();
        check("full_wake_no_issue", {31'b0, ALUworkEn}, 32'd0);
        tick();
        check("full_iss1_tag", {28'b0, wrtTag}, 32'd10);
        check("full_iss1_opO", operandO, 32'hAA);
        check("full_drop", {31'b0, rsFull}, 32'd0);
        tick();
        check("full_iss2_tag", {28'b0, wrtTag}, 32'd13);
        check("full_iss2_opO", operandO, 32'hBB);
        misTaken = 1;
        tick(); idle();
        check("flush_empty", {31'b0, rsFull}, 32'd0);

        // branch-free on the issuing mask, a stored mask, and a dispatch mask
        dis(ALU_AND, 4'd1, 32'd1, 32'd1, 4'd0, 4'd0, 32'h400, 4'b0110);
        tick(); idle();
        bFreeEn = 1; bFreeNum = 2'd1;
        tick(); idle();
        check("bfree_issue", {28'b0, instBranchTag}, 32'h4);
        dis(ALU_AND, 4'd2, 32'd0, 32'd1, 4'd5, 4'd0, 32'h404, 4'b1111);
        tick(); idle();
        bFreeEn = 1; bFreeNum = 2'd3;
        tick(); idle();
        cdbAEn = 1; cdbATag = 4'd5; cdbAData = 32'd3;
        tick(); idle();
        tick();
        check("bfree_stored", {28'b0, instBranchTag}, 32'h7);
        check("bfree_stored_opO", operandO, 32'd3);
        dis(ALU_AND, 4'd3, 32'd0, 32'd0, 4'd0, 4'd0, 32'h408, 4'b1111);
        bFreeEn = 1; bFreeNum = 2'd0;
        tick(); idle();
        tick();
        check("bfree_dispatch", {28'b0, instBranchTag}, 32'hE);

        // mispredict in the cycle after the first issue
        dis(ALU_ADD, 4'd1, 32'd1, 32'd1, 4'd0, 4'd0, 32'h500, 4'd0);
        tick();
        dis(ALU_ADD, 4'd2, 32'd2, 32'd2, 4'd0, 4'd0, 32'h504, 4'd0);
        tick();
        check("mis_first_issue", {28'b0, wrtTag}, 32'd1);
        dis(ALU_ADD, 4'd3, 32'd3, 32'd3, 4'd0, 4'd0, 32'h508, 4'd0);
        misTaken = 1;
        tick(); idle();
        check("mis_en", {31'b0, ALUworkEn}, 32'd0);
        check("mis_full", {31'b0, rsFull}, 32'd0);
        tick();
        check("mis_en2", {31'b0, ALUworkEn}, 32'd0);
        dis(ALU_ADD, 4'd4, 32'd4, 32'd4, 4'd0, 4'd0, 32'h50C, 4'd0);
        tick(); idle();
        tick();
        check("mis_after", {28'b0, wrtTag}, 32'd4);

        // asynchronous reset mid-operation
        dis(ALU_ADD, 4'd5, 32'd0, 32'd0, 4'd8, 4'd0, 32'h600, 4'd0);
        tick(); idle();
        #2 rst = 1;
        #1 check("async_rst_full", {31'b0, rsFull}, 32'd0);
        check("async_rst_en", {31'b0, ALUworkEn}, 32'd0);
        #3 rst = 0;
        tick();
        cdbAEn = 1; cdbATag = 4'd8; cdbAData = 32'd1;
        tick(); idle();
        tick();
        check("async_rst_gone", {31'b0, ALUworkEn}, 32'd0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
